// File: rtl/remote_key_scheduler_pkg.sv
// Shared constants and types for the IR key scheduler: the "no key" code,
// the valid NEC key-code range and the hold-off filter states.
package remote_pkg;

    localparam logic [7:0] KEY_NONE    = 8'hFF;
    localparam logic [7:0] NEC_KEY_MAX = 8'hFE;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_HOLD = 1'b1
    } filter_state_t;

endpackage

// File: rtl/remote_key_scheduler_fifo.sv
// Small key FIFO: DEPTH x W entries with occupancy count and asynchronous active-low reset.
// The head output is taken straight from storage, so pop never reaches dout combinationally.
module key_fifo #(
    parameter int              W     = 8,
    parameter int              DEPTH = 4,
    parameter logic [W-1:0]    NONE  = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = empty ? NONE : mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/remote_key_scheduler.sv
// Turns the NEC decoder's (key, ready) level output into a queue of key events:
// edge detect, auto-repeat hold-off filter, FIFO and a sticky overflow flag.
module remote_key_scheduler
    import remote_pkg::*;
#(
    parameter int KEY_W    = 8,
    parameter int DEPTH    = 4,
    parameter int HOLD_CYC = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [KEY_W-1:0]           key_in,
    input  logic                       key_stb,
    output logic [KEY_W-1:0]           key_out,
    output logic                       key_valid,
    input  logic                       key_ack,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output filter_state_t              state_dbg
);

    localparam int                 CW    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [KEY_W-1:0]   KNONE = KEY_W'(KEY_NONE);
    localparam logic [KEY_W-1:0]   KMAX  = KEY_W'(NEC_KEY_MAX);

    logic              stb_q;
    logic              evt;
    logic              repeat_hit;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              drop;
    logic [KEY_W-1:0]  last_key;
    logic [CW-1:0]     hold_cnt;
    filter_state_t     state;

    // Only a rising edge of ready carrying an in-range code is an event.
    assign evt        = key_stb & ~stb_q & (key_in <= KMAX);
    // Once the count has reached zero the window is over, even before the FSM leaves HOLD.
    assign repeat_hit = (state == F_HOLD) && (hold_cnt != '0) && (key_in == last_key);
    assign push       = evt & ~repeat_hit;
    assign pop        = key_valid & key_ack;
    assign drop       = push & full & ~pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stb_q    <= 1'b0;
            last_key <= KNONE;
            hold_cnt <= '0;
            state    <= F_IDLE;
            overflow <= 1'b0;
        end else begin
            stb_q <= key_stb;
            if (evt) begin
                last_key <= key_in;
                hold_cnt <= CW'(HOLD_CYC - 1);
                state    <= F_HOLD;
            end else if (state == F_HOLD) begin
                if (hold_cnt == '0) state <= F_IDLE;
                else                hold_cnt <= hold_cnt - CW'(1);
            end
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    key_fifo #(
        .W     (KEY_W),
        .DEPTH (DEPTH),
        .NONE  (KNONE)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (key_in),
        .dout  (key_out),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign key_valid = ~empty;
    assign state_dbg = state;

endmodule

// File: tb/tb_remote_key_scheduler.sv
// Directed bench for remote_key_scheduler: a queue/timestamp model checked every cycle,
// plus literal expectations for each scenario.
module tb_remote_key_scheduler;
    import remote_pkg::*;

    localparam int KEY_W    = 8;
    localparam int DEPTH    = 4;
    localparam int HOLD_CYC = 64;
    localparam int LW       = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic [KEY_W-1:0]  key_in;
    logic              key_stb;
    logic [KEY_W-1:0]  key_out;
    logic              key_valid;
    logic              key_ack;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              ovf_clr;
    filter_state_t     state_dbg;

    int checks   = 0;
    int failures = 0;

    remote_key_scheduler #(
        .KEY_W    (KEY_W),
        .DEPTH    (DEPTH),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_stb   (key_stb),
        .key_out   (key_out),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .level     (level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: accepted keys, cycle counter and end of the current hold-off window
    logic [KEY_W-1:0] exp_q[$];
    logic             m_prev_stb;
    logic [KEY_W-1:0] m_last;
    int               m_now;
    int               m_hold_until;
    logic             m_ovf;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            m_prev_stb   = 1'b0;
            m_last       = 8'hFF;
            m_now        = 0;
            m_hold_until = 0;
            m_ovf        = 1'b0;
        end else begin
            logic e, acc, pp, dropped;
            e  = key_stb && !m_prev_stb && (key_in != 8'hFF);
            m_prev_stb = key_stb;
            pp  = (exp_q.size() > 0) && key_ack;
            acc = e && ((m_now >= m_hold_until) || (key_in != m_last));
            if (e) begin
                m_last       = key_in;
                m_hold_until = m_now + HOLD_CYC;
            end
            dropped = acc && (exp_q.size() == DEPTH) && !pp;
            if (dropped)      m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (pp) void'(exp_q.pop_front());
            if (acc && !dropped) exp_q.push_back(key_in);
            m_now++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard compare, every cycle away from the active edge
    always @(negedge clk) begin
        chk("cmp_valid", 32'(key_valid), 32'(exp_q.size() != 0));
        chk("cmp_out", 32'(key_out), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'hFF);
        chk("cmp_level", 32'(level), 32'(exp_q.size()));
        chk("cmp_ovf", 32'(overflow), 32'(m_ovf));
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input logic [KEY_W-1:0] k, input int high);
        key_in  = k;
        key_stb = 1'b1;
        repeat (high) tick();
        key_stb = 1'b0;
        tick();
    endtask

    task automatic drain();
        key_ack = 1'b1;
        idle(DEPTH + 1);
        key_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0; key_in = '0; key_stb = 1'b0; key_ack = 1'b0; ovf_clr = 1'b0;
        idle(3);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_out", 32'(key_out), 32'hFF);
        chk("rst_level", 32'(level), 32'd0);
        rst = 1'b1;
        idle(2);

        // 1: single key with ready held three cycles
        key_in = 8'h05; key_stb = 1'b1;
        chk("t1_pre_valid", 32'(key_valid), 32'd0);
        tick();
        chk("t1_valid_lat", 32'(key_valid), 32'd1);
        chk("t1_out", 32'(key_out), 32'h05);
        idle(2);
        key_stb = 1'b0;
        tick();
        chk("t1_level", 32'(level), 32'd1);

        // 2: held key repeats inside the hold-off window
        drain(); idle(70);
        for (int i = 0; i < 5; i++) begin
            press(8'h07, 3);
            idle(16);
        end
        chk("t2_level_one", 32'(level), 32'd1);
        idle(70);
        press(8'h07, 3);
        chk("t2_level_two", 32'(level), 32'd2);
        chk("t2_out", 32'(key_out), 32'h07);

        // 3: different keys inside hold-off both accepted, in order
        drain(); idle(70);
        press(8'h01, 2);
        idle(2);
        press(8'h02, 2);
        chk("t3_head", 32'(key_out), 32'h01);
        key_ack = 1'b1; tick(); key_ack = 1'b0;
        chk("t3_second", 32'(key_out), 32'h02);

        // 4: full FIFO, drop, simultaneous push/pop, overflow clear and set-wins
        drain(); idle(70);
        press(8'h11, 1); press(8'h12, 1); press(8'h13, 1); press(8'h14, 1);
        chk("t4_full_level", 32'(level), 32'd4);
        chk("t4_ovf_before", 32'(overflow), 32'd0);
        press(8'h15, 1);
        chk("t4_ovf_set", 32'(overflow), 32'd1);
        chk("t4_level_drop", 32'(level), 32'd4);
        key_in = 8'h16; key_stb = 1'b1; key_ack = 1'b1;
        tick();
        key_ack = 1'b0; key_stb = 1'b0;
        tick();
        chk("t4_level_swap", 32'(level), 32'd4);
        chk("t4_head_adv", 32'(key_out), 32'h12);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        key_in = 8'h17; key_stb = 1'b1; ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0; key_stb = 1'b0;
        tick();
        chk("t4_set_wins", 32'(overflow), 32'd1);
        key_ack = 1'b1; idle(3); key_ack = 1'b0;
        chk("t4_tail", 32'(key_out), 32'h16);

        // 5: 0xFF code ignored, ack on empty ignored
        drain(); idle(70);
        chk("t5_idle", 32'(state_dbg), 32'(F_IDLE));
        press(8'hFF, 2);
        chk("t5_ff_level", 32'(level), 32'd0);
        chk("t5_ff_state", 32'(state_dbg), 32'(F_IDLE));
        key_ack = 1'b1; idle(2); key_ack = 1'b0;
        chk("t5_ack_level", 32'(level), 32'd0);
        chk("t5_ack_out", 32'(key_out), 32'hFF);

        // 6: asynchronous reset mid-operation
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        press(8'h21, 2); press(8'h22, 2); press(8'h23, 2);
        chk("t6_level3", 32'(level), 32'd3);
        chk("t6_hold", 32'(state_dbg), 32'(F_HOLD));
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(key_valid), 32'd0);
        chk("t6_rst_out", 32'(key_out), 32'hFF);
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_ovf", 32'(overflow), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        press(8'h23, 2);
        chk("t6_after_level", 32'(level), 32'd1);
        chk("t6_after_out", 32'(key_out), 32'h23);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
